// File: rtl/xor_stream_pkg.sv
// Shared types and helpers for xor_stream_unit: FSM states, mode encodings and lane parity.
// Optional feature macro used by the design files: XOR_PARITY_CHECK_EN.
package xor_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic MODE_PAIR  = 1'b0;
    localparam logic MODE_FRAME = 1'b1;

    // Widest lane lane_parity accepts; narrower lanes are zero-extended, which leaves parity unchanged.
    localparam int LANE_MAX_W = 64;

    function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/xor_lane.sv
// One XOR lane: a^b, frame accumulator, registered result and its parity.
// XOR_PARITY_CHECK_EN exposes the parity of the value about to be loaded.
module xor_lane
    import xor_stream_pkg::*;
#(
    parameter int W = 8
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_acc_start,
    input  logic         i_acc_step,
    input  logic         i_acc_clr,
    input  logic         i_y_load,
    input  logic         i_y_from_acc,
    output logic [W-1:0] o_y,
    output logic         o_parity
`ifdef XOR_PARITY_CHECK_EN
    ,
    output logic         o_parity_next
`endif
);

    logic [W-1:0] r_acc;
    logic [W-1:0] r_y;
    logic         r_parity;
    logic [W-1:0] w_ab;
    logic [W-1:0] w_acc_ab;
    logic [W-1:0] w_y_next;
    logic         w_parity_next;

    assign w_ab          = i_a ^ i_b;
    assign w_acc_ab      = r_acc ^ w_ab;
    assign w_y_next      = i_y_from_acc ? w_acc_ab : w_ab;
    assign w_parity_next = lane_parity(LANE_MAX_W'(w_y_next));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_y      <= '0;
            r_parity <= 1'b0;
        end else begin
            // Clear outranks start/step: the closing beat folds into y on the same edge acc is zeroed.
            if (i_acc_clr)        r_acc <= '0;
            else if (i_acc_start) r_acc <= w_ab;
            else if (i_acc_step)  r_acc <= w_acc_ab;

            if (i_y_load) begin
                r_y      <= w_y_next;
                r_parity <= w_parity_next;
            end
        end
    end

    assign o_y      = r_y;
    assign o_parity = r_parity;
`ifdef XOR_PARITY_CHECK_EN
    assign o_parity_next = w_parity_next;
`endif

endmodule

// File: rtl/xor_stream_unit.sv
// CH-lane registered XOR with PAIR (one result per beat) and FRAME (XOR over FRAME_LEN beats) modes.
// XOR_PARITY_CHECK_EN adds exp_par/par_err sticky parity comparison on every output load.
module xor_stream_unit
    import xor_stream_pkg::*;
#(
    parameter int CH        = 4,
    parameter int W         = 8,
    parameter int FRAME_LEN = 16
)
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mode,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CH*W-1:0]                a,
    input  logic [CH*W-1:0]                b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CH*W-1:0]                y,
    output logic [CH-1:0]                  parity,
    output logic [$clog2(FRAME_LEN+1)-1:0] beat_cnt
`ifdef XOR_PARITY_CHECK_EN
    ,
    input  logic [CH-1:0]                  exp_par,
    output logic [CH-1:0]                  par_err
`endif
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    state_e        r_state;
    state_e        w_next_state;
    logic          r_out_valid;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_in_ready;
    logic          w_acc_start;
    logic          w_acc_step;
    logic          w_acc_clr;
    logic          w_y_load;
    logic          w_y_from_acc;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_beat_cnt;
        w_in_ready   = 1'b0;
        w_acc_start  = 1'b0;
        w_acc_step   = 1'b0;
        w_acc_clr    = 1'b0;
        w_y_load     = 1'b0;
        w_y_from_acc = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = !r_out_valid || out_ready;
                if (in_valid && w_in_ready) begin
                    if (mode == MODE_PAIR) begin
                        w_y_load = 1'b1;
                    end else begin
                        w_acc_start  = 1'b1;
                        w_cnt_next   = CW'(1);
                        w_next_state = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // Flush drops any beat offered in the same cycle.
                w_in_ready = !flush;
                if (flush) begin
                    w_acc_clr    = 1'b1;
                    w_cnt_next   = '0;
                    w_next_state = IDLE;
                end else if (in_valid) begin
                    if (r_beat_cnt == CW'(FRAME_LEN - 1)) begin
                        w_y_load     = 1'b1;
                        w_y_from_acc = 1'b1;
                        w_acc_clr    = 1'b1;
                        w_cnt_next   = '0;
                        w_next_state = DRAIN;
                    end else begin
                        w_acc_step = 1'b1;
                        w_cnt_next = r_beat_cnt + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (r_out_valid && out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            r_beat_cnt <= w_cnt_next;
            // A new result outranks the drain handshake on the same edge.
            if (w_y_load)                      r_out_valid <= 1'b1;
            else if (r_out_valid && out_ready) r_out_valid <= 1'b0;
        end
    end

`ifdef XOR_PARITY_CHECK_EN
    logic [CH-1:0] w_par_next;
    logic [CH-1:0] r_par_err;
`endif

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        xor_lane #(.W(W)) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_a          (a[gi*W +: W]),
            .i_b          (b[gi*W +: W]),
            .i_acc_start  (w_acc_start),
            .i_acc_step   (w_acc_step),
            .i_acc_clr    (w_acc_clr),
            .i_y_load     (w_y_load),
            .i_y_from_acc (w_y_from_acc),
            .o_y          (y[gi*W +: W]),
            .o_parity     (parity[gi])
`ifdef XOR_PARITY_CHECK_EN
            ,
            .o_parity_next(w_par_next[gi])
`endif
        );
    end

`ifdef XOR_PARITY_CHECK_EN
    // Flush clears the sticky flags in any state, even though it leaves IDLE/DRAIN untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_par_err <= '0;
        else if (flush)    r_par_err <= '0;
        else if (w_y_load) r_par_err <= r_par_err | (exp_par ^ w_par_next);
    end
    assign par_err = r_par_err;
`endif

    assign in_ready  = w_in_ready & rst_n;
    assign out_valid = r_out_valid;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_xor_stream_unit.sv
// Randomized self-checking bench for xor_stream_unit against a queue-based reference model.
// Define XOR_PARITY_CHECK_EN to also exercise the exp_par/par_err ports.
module tb_xor_stream_unit;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int FL = 16;
    localparam int DW = CH * W;
    localparam int CW = $clog2(FL + 1);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          mode      = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a         = '0;
    logic [DW-1:0] b         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] y;
    logic [CH-1:0] parity;
    logic [CW-1:0] beat_cnt;
`ifdef XOR_PARITY_CHECK_EN
    logic [CH-1:0] exp_par = '0;
    logic [CH-1:0] par_err;
    logic [CH-1:0] m_par_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xor_stream_unit #(.CH(CH), .W(W), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .parity   (parity),
        .beat_cnt (beat_cnt)
`ifdef XOR_PARITY_CHECK_EN
        ,
        .exp_par  (exp_par),
        .par_err  (par_err)
`endif
    );

    // Reference model: pending result plus the list of beats of the open frame.
    logic          m_valid;
    logic          m_from_frame;
    logic [DW-1:0] m_y;
    logic [DW-1:0] m_beats[$];
    logic          obs_ready;
    logic          exp_ready;

    function automatic logic [CH-1:0] ref_parity(input logic [DW-1:0] v);
        logic [CH-1:0] p;
        for (int i = 0; i < CH; i++) p[i] = 1'($countones(v[i*W +: W]) % 2);
        return p;
    endfunction

    function automatic logic [DW-1:0] frame_xor();
        logic [DW-1:0] r;
        r = '0;
        foreach (m_beats[i]) r = r ^ m_beats[i];
        return r;
    endfunction

    task automatic model_reset();
        m_valid      = 1'b0;
        m_from_frame = 1'b0;
        m_y          = '0;
        m_beats.delete();
`ifdef XOR_PARITY_CHECK_EN
        m_par_err = '0;
`endif
    endtask

    // One clock: drive on negedge, sample in_ready, advance model at posedge, settle 1 time unit.
    task automatic step(input logic iv, input logic md, input logic fl,
                        input logic [DW-1:0] aa, input logic [DW-1:0] bb, input logic ordy);
        logic          load;
        logic          frame;
        logic [DW-1:0] new_y;
        @(negedge clk);
        in_valid = iv; mode = md; flush = fl; a = aa; b = bb; out_ready = ordy;
        #1;
        obs_ready = in_ready;
        if (m_beats.size() > 0)          exp_ready = !fl;
        else if (m_valid && m_from_frame) exp_ready = 1'b0;
        else                              exp_ready = !m_valid || ordy;
        @(posedge clk);
        load = 1'b0; frame = 1'b0; new_y = '0;
        if (m_beats.size() > 0 && fl) begin
            m_beats.delete();
        end else if (iv && exp_ready) begin
            if (m_beats.size() > 0 || md) begin
                m_beats.push_back(aa ^ bb);
                if (m_beats.size() == FL) begin
                    new_y = frame_xor(); load = 1'b1; frame = 1'b1;
                    m_beats.delete();
                end
            end else begin
                new_y = aa ^ bb; load = 1'b1;
            end
        end
`ifdef XOR_PARITY_CHECK_EN
        if (fl)        m_par_err = '0;
        else if (load) m_par_err = m_par_err | (exp_par ^ ref_parity(new_y));
`endif
        if (load) begin
            m_y = new_y; m_valid = 1'b1; m_from_frame = frame;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0; m_from_frame = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] ra;
        ra = $urandom();
        step(1'b1, 1'b0, 1'b0, ra, 32'h5A5A_A5A5, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, $urandom(), $urandom(), 1'b1);
        n_tests++;
        if (beat_cnt !== CW'(3)) begin n_fail++; $display("FAIL reset_pre_cnt: got %0d want 3", beat_cnt); end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++;
        if (y !== '0) begin n_fail++; $display("FAIL reset_y: got %h want 0", y); end
        n_tests++;
        if (parity !== '0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", parity); end
        n_tests++;
        if (beat_cnt !== '0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pair();
        step(1'b1, 1'b0, 1'b0, 32'hFF00_F0AA, 32'h0F0F_FF55, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || y !== 32'hF00F_0FFF || parity !== 4'b0000) begin
            n_fail++;
            $display("FAIL pair_directed: valid=%b y=%h par=%b want 1 f00f0fff 0000", out_valid, y, parity);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_drain: valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a1, b1, a2, b2;
        a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
        step(1'b1, 1'b0, 1'b0, a1, b1, 1'b0);
        n_tests++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || y !== (a1 ^ b1)) begin
            n_fail++;
            $display("FAIL bp_first: rdy=%b valid=%b y=%h want 1 1 %h", obs_ready, out_valid, y, a1 ^ b1);
        end
        step(1'b1, 1'b0, 1'b0, a2, b2, 1'b0);
        n_tests++;
        if (obs_ready !== 1'b0 || y !== (a1 ^ b1) || parity !== ref_parity(a1 ^ b1)) begin
            n_fail++;
            $display("FAIL bp_hold: rdy=%b y=%h par=%b want 0 %h %b", obs_ready, y, parity, a1 ^ b1, ref_parity(a1 ^ b1));
        end
        step(1'b1, 1'b0, 1'b0, a2, b2, 1'b1);
        n_tests++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || y !== (a2 ^ b2)) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b valid=%b y=%h want 1 1 %h", obs_ready, out_valid, y, a2 ^ b2);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_frame();
        for (int i = 0; i < FL; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0101_0101, '0, 1'b1);
            if (i == 7) begin
                n_tests++;
                if (beat_cnt !== CW'(8)) begin n_fail++; $display("FAIL frame_mid_cnt: got %0d want 8", beat_cnt); end
            end
        end
        n_tests++;
        if (out_valid !== 1'b1 || y !== '0 || parity !== 4'b0000 || beat_cnt !== '0) begin
            n_fail++;
            $display("FAIL frame_even: valid=%b y=%h par=%b cnt=%0d want 1 0 0000 0", out_valid, y, parity, beat_cnt);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0101_0101, '0, 1'b0);
        n_tests++;
        if (obs_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL drain_hold: rdy=%b valid=%b want 0 1", obs_ready, out_valid);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0101_0101, '0, 1'b1);
        n_tests++;
        if (obs_ready !== 1'b0 || out_valid !== 1'b0 || beat_cnt !== '0) begin
            n_fail++; $display("FAIL drain_release: rdy=%b valid=%b cnt=%0d want 0 0 0", obs_ready, out_valid, beat_cnt);
        end
        // Mode is toggled after the first beat; the frame must carry on regardless.
        for (int i = 0; i < FL; i++)
            step(1'b1, (i == 0) ? 1'b1 : 1'(i % 2), 1'b0, (i < FL - 1) ? 32'h0101_0101 : 32'h0, '0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || y !== 32'h0101_0101 || parity !== 4'b1111) begin
            n_fail++;
            $display("FAIL frame_odd: valid=%b y=%h par=%b want 1 01010101 1111", out_valid, y, parity);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_flush();
        logic [DW-1:0] aa, bb, acc;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, $urandom(), $urandom(), 1'b1);
        n_tests++;
        if (beat_cnt !== CW'(7)) begin n_fail++; $display("FAIL flush_pre_cnt: got %0d want 7", beat_cnt); end
        step(1'b1, 1'b1, 1'b1, $urandom(), $urandom(), 1'b1);
        n_tests++;
        if (obs_ready !== 1'b0 || beat_cnt !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush: rdy=%b cnt=%0d valid=%b want 0 0 0", obs_ready, beat_cnt, out_valid);
        end
        acc = '0;
        for (int i = 0; i < FL; i++) begin
            aa = $urandom(); bb = $urandom();
            acc = acc ^ aa ^ bb;
            step(1'b1, 1'b1, 1'b0, aa, bb, 1'b1);
        end
        n_tests++;
        if (out_valid !== 1'b1 || y !== acc || parity !== ref_parity(acc)) begin
            n_fail++; $display("FAIL flush_next_frame: valid=%b y=%h par=%b want 1 %h %b", out_valid, y, parity, acc, ref_parity(acc));
        end
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            step(1'(($urandom() % 4) != 0), 1'($urandom() % 2), 1'(($urandom() % 40) == 0),
                 $urandom(), $urandom(), 1'(($urandom() % 3) != 0));
            n_tests++;
            if (obs_ready !== exp_ready || out_valid !== m_valid || y !== m_y ||
                parity !== ref_parity(m_y) || beat_cnt !== CW'(m_beats.size())) begin
                n_fail++;
                $display("FAIL random[%0d]: rdy=%b valid=%b y=%h par=%b cnt=%0d want %b %b %h %b %0d", i,
                         obs_ready, out_valid, y, parity, beat_cnt,
                         exp_ready, m_valid, m_y, ref_parity(m_y), m_beats.size());
            end
        end
        step(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

`ifdef XOR_PARITY_CHECK_EN
    task automatic test_parity_check();
        exp_par = 4'b0000;
        step(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0001_0001, '0, 1'b1);
        n_tests++;
        if (parity !== 4'b0101 || par_err !== 4'b0101 || par_err !== m_par_err) begin
            n_fail++; $display("FAIL par_err_set: par=%b err=%b want 0101 0101", parity, par_err);
        end
        exp_par = 4'b0101;
        step(1'b1, 1'b0, 1'b0, 32'h0001_0001, '0, 1'b1);
        n_tests++;
        if (par_err !== 4'b0101) begin n_fail++; $display("FAIL par_err_sticky: err=%b want 0101", par_err); end
        step(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
        n_tests++;
        if (par_err !== 4'b0000) begin n_fail++; $display("FAIL par_err_flush: err=%b want 0000", par_err); end
        exp_par = 4'b0000;
    endtask
`endif

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_pair();
        test_back_to_back();
        test_frame();
        test_flush();
`ifdef XOR_PARITY_CHECK_EN
        test_parity_check();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
